// File: rtl/fft_vga_pkg.sv
// fft_vga_pkg
//   Shared types and constants for the FFT-to-spectrum-RAM path.
//   - state_t      : writer FSM states (IDLE, FILL, DRAIN)
//   - NUM_BINS_DEF : default bins per frame / RAM depth
//   - MAX_VAL_DEF  : default clamp ceiling (display bar height in pixels)
//   - BE_ALL       : full-word byteenable used on every RAM write
package fft_vga_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int          NUM_BINS_DEF = 1024;
  localparam int          MAX_VAL_DEF  = 479;
  localparam logic [3:0]  BE_ALL       = 4'hF;

endpackage

// File: rtl/fft_bin_scale_clamp.sv
// fft_bin_scale_clamp
//   Combinational scale-and-saturate of one FFT magnitude bin:
//   clamped = min(in_data >> SHIFT, MAX_VAL), zero-extended to 32 bits.
//   Ports:
//     in_data [IN_W-1:0] : raw bin magnitude
//     clamped [31:0]     : scaled and saturated value
module fft_bin_scale_clamp #(
  parameter int IN_W    = 32,
  parameter int SHIFT   = 8,
  parameter int MAX_VAL = 479
) (
  input  logic [IN_W-1:0] in_data,
  output logic [31:0]     clamped
);

  logic [IN_W-1:0] scaled;

  assign scaled  = in_data >> SHIFT;
  assign clamped = (scaled > IN_W'(MAX_VAL)) ? 32'(MAX_VAL) : 32'(scaled);

endmodule

// File: rtl/fft_bin_ram_writer.sv
// fft_bin_ram_writer
//   Takes a valid/ready FFT magnitude stream framed by sop/eop, scales and
//   clamps each bin and writes it into the spectrum RAM write slave, one
//   registered write per accepted bin (write appears the cycle after accept).
//   Optional feature macro: FFT_BIN_PEAK_HOLD_EN (per-frame peak value/index).
//   Ports:
//     clk, reset_n (sync, active low)
//     in_valid/in_ready/in_data/in_sop/in_eop : input bin stream
//     freeze        : hold off new frames while idle (ignored mid-frame)
//     ram_*         : RAM write slave (address, chipselect, write, be, data)
//     frame_done    : one-cycle pulse with the frame's last write
//     frame_err     : sticky framing error, cleared by err_clr
//     frame_count   : completed frames (wraps)
//     peak_val/peak_idx (FFT_BIN_PEAK_HOLD_EN only): last frame's peak
module fft_bin_ram_writer
  import fft_vga_pkg::*;
#(
  parameter int NUM_BINS = NUM_BINS_DEF,
  parameter int ADDR_W   = 10,
  parameter int IN_W     = 32,
  parameter int SHIFT    = 8,
  parameter int MAX_VAL  = MAX_VAL_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic              freeze,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [3:0]        ram_byteenable,
  output logic [31:0]       ram_writedata,
  output logic              frame_done,
  output logic              frame_err,
  input  logic              err_clr,
  output logic [15:0]       frame_count
`ifdef FFT_BIN_PEAK_HOLD_EN
  ,
  output logic [31:0]       peak_val,
  output logic [ADDR_W-1:0] peak_idx
`endif
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BINS - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] index, index_next;
  logic              accept;
  logic              wr_next;
  logic              done_next;
  logic              err_set;
  logic [ADDR_W-1:0] addr_next;
  logic [31:0]       clamped;

  assign accept = in_valid & in_ready;

  fft_bin_scale_clamp #(
    .IN_W   (IN_W),
    .SHIFT  (SHIFT),
    .MAX_VAL(MAX_VAL)
  ) u_scale (
    .in_data(in_data),
    .clamped(clamped)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      index <= '0;
    end else begin
      state <= state_next;
      index <= index_next;
    end
  end

  // Next-state and per-bin write decision
  always_comb begin
    state_next = state;
    index_next = index;
    wr_next    = 1'b0;
    done_next  = 1'b0;
    err_set    = 1'b0;
    addr_next  = index;
    if (accept) begin
      case (state)
        IDLE, DRAIN: begin
          // A sop starts a frame from either state; other bins are dropped.
          if (in_sop) begin
            wr_next   = 1'b1;
            addr_next = '0;
            if (in_eop) begin
              done_next  = 1'b1;
              state_next = IDLE;
              index_next = '0;
            end else begin
              index_next = ADDR_W'(1);
              state_next = FILL;
            end
          end else if (state == DRAIN && in_eop) begin
            state_next = IDLE;
          end
        end
        FILL: begin
          wr_next = 1'b1;
          if (in_sop) begin
            // Restart: the interrupted frame is neither done nor counted.
            err_set   = 1'b1;
            addr_next = '0;
            if (in_eop) begin
              done_next  = 1'b1;
              state_next = IDLE;
              index_next = '0;
            end else begin
              index_next = ADDR_W'(1);
            end
          end else if (in_eop) begin
            done_next  = 1'b1;
            err_set    = (index != LAST_IDX);
            state_next = IDLE;
            index_next = '0;
          end else if (index == LAST_IDX) begin
            // RAM full without eop: close the frame, swallow the excess.
            done_next  = 1'b1;
            err_set    = 1'b1;
            state_next = DRAIN;
            index_next = '0;
          end else begin
            index_next = index + ADDR_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode: frames are atomic, so freeze only gates IDLE.
  always_comb begin
    in_ready = reset_n & ((state != IDLE) | ~freeze);
  end

  // Registered RAM port and status
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ram_address    <= '0;
      ram_chipselect <= 1'b0;
      ram_write      <= 1'b0;
      ram_byteenable <= 4'h0;
      ram_writedata  <= '0;
      frame_done     <= 1'b0;
      frame_err      <= 1'b0;
      frame_count    <= '0;
    end else begin
      ram_chipselect <= wr_next;
      ram_write      <= wr_next;
      ram_byteenable <= wr_next ? BE_ALL : 4'h0;
      if (wr_next) begin
        ram_address   <= addr_next;
        ram_writedata <= clamped;
      end
      frame_done <= done_next;
      if (done_next) begin
        frame_count <= frame_count + 16'd1;
      end
      // A new error beats a simultaneous clear.
      frame_err <= err_set | (frame_err & ~err_clr);
    end
  end

`ifdef FFT_BIN_PEAK_HOLD_EN
  logic [31:0]       run_val;
  logic [ADDR_W-1:0] run_idx;
  logic [31:0]       cand_val;
  logic [ADDR_W-1:0] cand_idx;

  // Address 0 is only ever written at frame start, so it reseeds the max.
  // Strict greater-than keeps the lower index on ties.
  always_comb begin
    cand_val = run_val;
    cand_idx = run_idx;
    if (addr_next == '0) begin
      cand_val = clamped;
      cand_idx = '0;
    end else if (clamped > run_val) begin
      cand_val = clamped;
      cand_idx = addr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_val  <= '0;
      run_idx  <= '0;
      peak_val <= '0;
      peak_idx <= '0;
    end else begin
      if (wr_next) begin
        run_val <= cand_val;
        run_idx <= cand_idx;
      end
      if (done_next) begin
        peak_val <= cand_val;
        peak_idx <= cand_idx;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fft_bin_ram_writer.sv
module tb_fft_bin_ram_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sop;
  logic        in_eop;
  logic        freeze;
  logic [9:0]  ram_address;
  logic        ram_chipselect;
  logic        ram_write;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata;
  logic        frame_done;
  logic        frame_err;
  logic        err_clr;
  logic [15:0] frame_count;
`ifdef FFT_BIN_PEAK_HOLD_EN
  logic [31:0] peak_val;
  logic [9:0]  peak_idx;
  typedef logic [107:0] obs_t;
`else
  typedef logic [65:0] obs_t;
`endif

  fft_bin_ram_writer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_sop        (in_sop),
    .in_eop        (in_eop),
    .freeze        (freeze),
    .ram_address   (ram_address),
    .ram_chipselect(ram_chipselect),
    .ram_write     (ram_write),
    .ram_byteenable(ram_byteenable),
    .ram_writedata (ram_writedata),
    .frame_done    (frame_done),
    .frame_err     (frame_err),
    .err_clr       (err_clr),
    .frame_count   (frame_count)
`ifdef FFT_BIN_PEAK_HOLD_EN
    ,
    .peak_val      (peak_val),
    .peak_idx      (peak_idx)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: frame position tracking from the framing rules.
  int          m_mode;   // 0 waiting for sop, 1 inside frame, 2 discarding to eop
  int          m_pos;
  logic        m_wr, m_done, m_err;
  logic [9:0]  m_addr;
  logic [31:0] m_data;
  logic [15:0] m_count;
  int unsigned m_run_val, m_run_idx, m_peak_val, m_peak_idx;

  function automatic int unsigned clampv(input logic [31:0] d);
    int unsigned s;
    s = d / 256;
    return (s > 479) ? 479 : s;
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_pos = 0; m_wr = 0; m_done = 0; m_err = 0;
    m_addr = '0; m_data = '0; m_count = '0;
    m_run_val = 0; m_run_idx = 0; m_peak_val = 0; m_peak_idx = 0;
  endfunction

  function automatic void model_idle();
    m_wr = 0;
    m_done = 0;
  endfunction

  function automatic void emit(input int addr, input logic [31:0] d, input bit done);
    int unsigned v;
    v = clampv(d);
    m_wr = 1; m_addr = addr[9:0]; m_data = v;
    if (addr == 0) begin
      m_run_val = v; m_run_idx = 0;
    end else if (v > m_run_val) begin
      m_run_val = v; m_run_idx = addr;
    end
    if (done) begin
      m_done = 1;
      m_count = m_count + 16'd1;
      m_peak_val = m_run_val;
      m_peak_idx = m_run_idx;
    end
  endfunction

  function automatic void model_step(input logic [31:0] d, input bit s, input bit e);
    m_wr = 0; m_done = 0;
    if (m_mode != 1) begin
      if (s) begin
        emit(0, d, e);
        if (e) m_mode = 0;
        else begin m_mode = 1; m_pos = 1; end
      end else if (m_mode == 2 && e) begin
        m_mode = 0;
      end
    end else if (s) begin
      m_err = 1;
      emit(0, d, e);
      if (e) m_mode = 0;
      else m_pos = 1;
    end else if (e) begin
      emit(m_pos, d, 1);
      if (m_pos != 1023) m_err = 1;
      m_mode = 0;
    end else if (m_pos == 1023) begin
      emit(m_pos, d, 1);
      m_err = 1;
      m_mode = 2;
    end else begin
      emit(m_pos, d, 0);
      m_pos++;
    end
  endfunction

  function automatic obs_t exp_vec();
    return {m_wr, m_wr, (m_wr ? 4'hF : 4'h0), m_addr, m_data, m_done, m_err, m_count
`ifdef FFT_BIN_PEAK_HOLD_EN
            , m_peak_val, m_peak_idx[9:0]
`endif
           };
  endfunction

  function automatic obs_t dut_vec();
    return {ram_chipselect, ram_write, ram_byteenable, ram_address, ram_writedata,
            frame_done, frame_err, frame_count
`ifdef FFT_BIN_PEAK_HOLD_EN
            , peak_val, peak_idx
`endif
           };
  endfunction

  // Drive one bin from a negedge; return at the negedge after acceptance.
  task automatic send_bin(input logic [31:0] d, input bit s, input bit e,
                          output obs_t obs, output bit ok);
    bit ok_now;
    in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      #1;
      ok_now = in_ready;
      @(posedge clk);
      if (ok_now) ok = 1'b1;
      @(negedge clk);
    end
    obs = dut_vec();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    repeat (n) @(negedge clk);
    model_idle();
  endtask

  task automatic test_reset();
    obs_t obs;
    model_reset();
    obs = dut_vec();
    tests++;
    if (obs !== exp_vec()) begin
      fails++; $display("FAIL reset_outputs: got %h want %h", obs, exp_vec());
    end
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready: got %b want 0", in_ready);
    end
    reset_n = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL ready_after_reset: got %b want 1", in_ready);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_normal_frame();
    obs_t obs; bit ok; int dones = 0;
    for (int i = 0; i < 1024; i++) begin
      send_bin(32'(i) << 8, i == 0, i == 1023, obs, ok);
      model_step(32'(i) << 8, i == 0, i == 1023);
      if (frame_done === 1'b1) dones++;
      tests++;
      if (!ok || obs !== exp_vec()) begin
        fails++; $display("FAIL normal bin %0d: accepted=%0b got %h want %h", i, ok, obs, exp_vec());
      end
    end
    tests++;
    if (dones != 1 || frame_count !== 16'd1 || ram_address !== 10'd1023) begin
      fails++; $display("FAIL normal_summary: dones=%0d count=%0d last_addr=%0d want 1 1 1023",
                        dones, frame_count, ram_address);
    end
    idle_cycles(1);
    $display("[TB] normal frame: 1024 bins, count=%0d", frame_count);
  endtask

  task automatic test_clamp_shift();
    logic [31:0] din [4];
    int unsigned want [4];
    obs_t obs; bit ok;
    din[0] = 32'hFFFF_FFFF; din[1] = 32'h0001_DF00; din[2] = 32'h0001_E000; din[3] = 32'h0;
    want[0] = 479; want[1] = 479; want[2] = 479; want[3] = 0;
    for (int i = 0; i < 4; i++) begin
      send_bin(din[i], i == 0, i == 3, obs, ok);
      model_step(din[i], i == 0, i == 3);
      tests++;
      if (!ok || obs !== exp_vec() || ram_writedata !== want[i]) begin
        fails++; $display("FAIL clamp bin %0d: data=%0d want %0d (vec %h vs %h)",
                          i, ram_writedata, want[i], obs, exp_vec());
      end
    end
    idle_cycles(1);
    $display("[TB] clamp/shift frame done, err=%0b", frame_err);
  endtask

  task automatic test_short_frame();
    obs_t obs; bit ok; logic [31:0] d;
    for (int i = 0; i < 100; i++) begin
      d = $urandom;
      send_bin(d, i == 0, i == 99, obs, ok);
      model_step(d, i == 0, i == 99);
      tests++;
      if (!ok || obs !== exp_vec()) begin
        fails++; $display("FAIL short bin %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    tests++;
    if (frame_err !== 1'b1 || frame_done !== 1'b1) begin
      fails++; $display("FAIL short_err: err=%b done=%b want 1 1", frame_err, frame_done);
    end
    idle_cycles(2);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_err = 0;
    tests++;
    if (frame_err !== 1'b0 || dut_vec() !== exp_vec()) begin
      fails++; $display("FAIL err_clr: err=%b want 0", frame_err);
    end
    $display("[TB] short frame 100 bins, err cleared");
  endtask

  task automatic test_mid_sop();
    obs_t obs; bit ok; logic [31:0] d;
    logic [15:0] count_before;
    count_before = frame_count;
    for (int i = 0; i < 1524; i++) begin
      d = $urandom_range(0, 600 * 256);
      send_bin(d, i == 0 || i == 500, i == 1523, obs, ok);
      model_step(d, i == 0 || i == 500, i == 1523);
      tests++;
      if (!ok || obs !== exp_vec()) begin
        fails++; $display("FAIL midsop bin %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    tests++;
    if (frame_err !== 1'b1 || frame_count !== count_before + 16'd1) begin
      fails++; $display("FAIL midsop_summary: err=%b count=%0d want 1 %0d",
                        frame_err, frame_count, count_before + 16'd1);
    end
    idle_cycles(1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; m_err = 0;
    $display("[TB] mid-frame sop restart checked");
  endtask

  task automatic test_long_frame();
    obs_t obs; bit ok; logic [31:0] d;
    for (int i = 0; i < 1030; i++) begin
      d = $urandom;
      send_bin(d, i == 0, i == 1029, obs, ok);
      model_step(d, i == 0, i == 1029);
      tests++;
      if (!ok || obs !== exp_vec()) begin
        fails++; $display("FAIL long bin %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    idle_cycles(1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; m_err = 0;
    $display("[TB] long frame drained");
  endtask

  task automatic test_freeze();
    obs_t obs; bit ok; logic [31:0] d;
    freeze = 1'b1;
    in_valid = 1'b1; in_sop = 1'b1; in_data = 32'h1234;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++;
      if (in_ready !== 1'b0 || ram_write !== 1'b0) begin
        fails++; $display("FAIL freeze_idle cycle %0d: ready=%b write=%b want 0 0", c, in_ready, ram_write);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; in_sop = 1'b0;
    freeze = 1'b0;
    model_idle();
    for (int i = 0; i < 1024; i++) begin
      if (i == 10) freeze = 1'b1;
      d = $urandom;
      send_bin(d, i == 0, i == 1023, obs, ok);
      model_step(d, i == 0, i == 1023);
      tests++;
      if (!ok || obs !== exp_vec()) begin
        fails++; $display("FAIL freeze_fill bin %0d: accepted=%0b got %h want %h", i, ok, obs, exp_vec());
      end
    end
    freeze = 1'b0;
    idle_cycles(1);
    $display("[TB] freeze idle/fill checked");
  endtask

  task automatic test_reset_mid_frame();
    obs_t obs; bit ok; logic [31:0] d;
    for (int i = 0; i < 300; i++) begin
      d = $urandom;
      send_bin(d, i == 0, 1'b0, obs, ok);
      model_step(d, i == 0, 1'b0);
    end
    reset_n = 1'b0;
    in_valid = 1'b1; in_data = 32'hABCD_0000;
    @(posedge clk); @(negedge clk);
    model_reset();
    obs = dut_vec();
    tests++;
    if (obs !== exp_vec() || in_ready !== 1'b0) begin
      fails++; $display("FAIL reset_mid: got %h ready=%b want %h ready=0", obs, in_ready, exp_vec());
    end
    in_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    tests++;
    if (ram_write !== 1'b0 || dut_vec() !== exp_vec()) begin
      fails++; $display("FAIL reset_stray: write=%b want 0", ram_write);
    end
    for (int i = 0; i < 20; i++) begin
      d = $urandom;
      send_bin(d, i == 0, i == 19, obs, ok);
      model_step(d, i == 0, i == 19);
      tests++;
      if (!ok || obs !== exp_vec()) begin
        fails++; $display("FAIL post_reset bin %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    idle_cycles(1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; m_err = 0;
    $display("[TB] reset mid-frame checked, count=%0d", frame_count);
  endtask

  task automatic test_random_frames();
    obs_t obs; bit ok; logic [31:0] d; bit s, e; int len;
    for (int f = 0; f < 20; f++) begin
      // Stray non-sop bins while idle must be swallowed silently.
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        d = $urandom; e = 1'($urandom_range(0, 1));
        send_bin(d, 1'b0, e, obs, ok);
        model_step(d, 1'b0, e);
        tests++;
        if (!ok || obs !== exp_vec()) begin
          fails++; $display("FAIL rand_stray f%0d: got %h want %h", f, obs, exp_vec());
        end
      end
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        d = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 500 * 256);
        s = (i == 0); e = (i == len - 1);
        send_bin(d, s, e, obs, ok);
        model_step(d, s, e);
        tests++;
        if (!ok || obs !== exp_vec()) begin
          fails++; $display("FAIL rand f%0d bin %0d: got %h want %h", f, i, obs, exp_vec());
        end
        if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
      end
      idle_cycles(1);
    end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; m_err = 0;
    $display("[TB] random frames done, count=%0d", frame_count);
  endtask

`ifdef FFT_BIN_PEAK_HOLD_EN
  task automatic test_peak();
    obs_t obs; bit ok; logic [31:0] d;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) d = 32'd479 << 8;
      else if (i == 20) d = 32'hFFFF_FFFF;
      else d = $urandom_range(0, 478 * 256);
      send_bin(d, i == 0, i == 29, obs, ok);
      model_step(d, i == 0, i == 29);
      tests++;
      if (!ok || obs !== exp_vec()) begin
        fails++; $display("FAIL peak bin %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    tests++;
    if (peak_idx !== 10'd10 || peak_val !== 32'd479) begin
      fails++; $display("FAIL peak_tie: idx=%0d val=%0d want 10 479", peak_idx, peak_val);
    end
    idle_cycles(1);
    $display("[TB] peak idx=%0d val=%0d", peak_idx, peak_val);
  endtask
`endif

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0;
    freeze = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_normal_frame();
    test_clamp_shift();
    test_short_frame();
    test_mid_sop();
    test_long_frame();
    test_freeze();
    test_reset_mid_frame();
    test_random_frames();
`ifdef FFT_BIN_PEAK_HOLD_EN
    test_peak();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft_bin_ram_writer.md
Name: fft_bin_ram_writer

Overview:
- Upstream feeder for the 1024x32 single-port spectrum RAM that the VGA renderer reads.
- Accepts a streaming FFT magnitude frame with valid/ready and sop/eop framing, then scales and clamps each bin to display height.
- Writes bins sequentially into the RAM's write slave: one write per cycle, with registered outputs.
- Reports frame completion, framing errors and a frame count to the Nios/control side.

Parameters:
- NUM_BINS, 1024, bins per frame; also the RAM depth. Must be ≤ 2^ADDR_W.
- ADDR_W, 10, RAM address width.
- IN_W, 32, input magnitude width.
- SHIFT, 8, right-shift applied to the magnitude before clamping.
- MAX_VAL, 479, clamp ceiling (display bar height in pixels).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  input bin valid
- in_ready  out  1  block can accept a bin
- in_data  in  IN_W  bin magnitude
- in_sop  in  1  first bin of frame
- in_eop  in  1  last bin of frame
- freeze  in  1  host hold; stall frame acceptance
- ram_address  out  ADDR_W  RAM word address
- ram_chipselect  out  1  RAM select
- ram_write  out  1  RAM write strobe
- ram_byteenable  out  4  always 4'hF while writing, else 4'h0
- ram_writedata  out  32  scaled, clamped bin
- frame_done  out  1  one-cycle pulse when a frame's last write issues
- frame_err  out  1  sticky framing error; cleared by err_clr
- err_clr  in  1  clears frame_err
- frame_count  out  16  completed frames, wraps at 65535 -> 0

Behaviour:
- Reset (reset_n low at a clk edge):
  - state = IDLE, in_ready = 0, ram_chipselect = 0, ram_write = 0.
  - ram_address = 0, ram_byteenable = 0, ram_writedata = 0.
  - frame_done = 0, frame_err = 0, frame_count = 0, bin index = 0.
- A reset arriving mid-frame abandons the frame. No further writes are issued, and RAM contents are left as they are.
- Handshake: a bin is accepted on a cycle where in_valid & in_ready. in_data may change only after acceptance.
- Datapath:
  - scaled = in_data >> SHIFT.
  - ram_writedata = (scaled > MAX_VAL) ? MAX_VAL : scaled, zero-extended to 32 bits.
- Latency: a bin accepted in cycle N produces ram_chipselect = ram_write = 1 with its address and data in cycle N+1. Write strobes are single-cycle per bin. Back-to-back accepts give one write per cycle.
- IDLE:
  - in_ready = ~freeze.
  - Non-sop bins are accepted and discarded, with no write and no error.
  - An accepted bin with sop writes address 0, sets index = 1 and moves to FILL.
  - A bin with both sop and eop is a 1-bin frame: write address 0, pulse frame_done, count the frame, stay in IDLE.
- FILL:
  - in_ready = 1. freeze is ignored mid-frame, so frames are atomic.
  - Each accepted bin writes address = index, then index increments.
  - eop with index == NUM_BINS-1: normal end. Pulse frame_done in the write cycle, increment frame_count, go to IDLE.
  - eop with index < NUM_BINS-1 (short frame): write the bin, set frame_err, pulse frame_done, increment frame_count, go to IDLE. Remaining addresses keep stale data.
  - index == NUM_BINS-1 without eop (long frame): write the bin, set frame_err, pulse frame_done, increment frame_count, go to DRAIN.
  - sop mid-frame: restart. Set frame_err, write this bin to address 0, set index = 1, stay in FILL, no frame_done.
- DRAIN: in_ready = 1. Discard bins until an accepted eop, then go to IDLE. A sop seen in DRAIN is handled as in IDLE (starts a new frame).
- err_clr and a new error in the same cycle: the error wins, so frame_err = 1.
- frame_done and frame_count update in the same cycle as the final ram_write.

Optional Feature:
- Macro: FFT_BIN_PEAK_HOLD_EN.
- When defined:
  - Adds outputs peak_val[31:0] and peak_idx[ADDR_W-1:0].
  - Tracks the maximum clamped value in the current frame. Ties keep the lower index.
  - Both outputs latch in the frame_done cycle, and both reset to 0.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package fft_vga_pkg holds:
  - the state enum (IDLE, FILL, DRAIN);
  - constants NUM_BINS_DEF = 1024 and MAX_VAL_DEF = 479;
  - the byteenable constant BE_ALL = 4'hF.
- One natural sub-module, fft_bin_scale_clamp: combinational shift-and-saturate, reused by the peak tracker.

Test Plan:
- Normal frame: 1024 bins with in_data = i<<8, sop on bin 0, eop on bin 1023 -> 1024 writes at addresses 0..1023 with data i clamped at 479; frame_done pulses once with the write to address 1023; frame_count = 1.
- Clamp and shift: bins 0xFFFFFFFF, 0x0001DF00, 0x0001E000, 0x00000000 -> writedata 479, 479, 479, 0.
- Short frame: eop on bin 99 -> writes to addresses 0..99, frame_err = 1, frame_done pulses, back in IDLE; err_clr returns frame_err to 0.
- Mid-frame sop at bin 500, then a full frame -> frame_err = 1, addresses restart at 0, frame_count increments only at the later eop.
- freeze = 1 in IDLE: in_ready = 0 and no writes. Asserting freeze mid-FILL does not stall; the frame completes.
- Reset_n pulsed low at bin 300, then a new frame -> all outputs at reset values on the next cycle, no stray write; the new frame writes from address 0. With FFT_BIN_PEAK_HOLD_EN, a frame containing 479 at bins 10 and 20 gives peak_idx = 10.
